// File: rtl/block_xfer_seq.sv
// block_xfer_seq: LDM/STM block transfer sequencer.
// Walks a 16-bit register list in ascending order, one memory transaction
// per set bit, with optional base writeback.
// Optional feature macro: BLOCK_XFER_DB_EN adds the `decrement` input for
// decrement-before addressing (default build: increment-after only).
module block_xfer_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        wb_en,
    input  logic [3:0]  rn,
    input  logic [15:0] reg_list,
`ifdef BLOCK_XFER_DB_EN
    input  logic        decrement,
`endif
    output logic        busy,
    output logic        done,
    output logic [3:0]  rf_A1,
    input  logic [31:0] rf_RD1,
    output logic [3:0]  rf_A3,
    output logic [31:0] rf_WD3,
    output logic        rf_WE3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, BASE, XFER, LWR, WB, DONE} state_t;

    state_t      state, state_nx;

    logic        ld_r, wb_r, dec_r;
    logic [3:0]  rn_r;
    logic [15:0] list_r;   // original list, kept for the writeback-skip test
    logic [15:0] pend;     // registers still to transfer
    logic [3:0]  idx;      // register of the current transaction
    logic [31:0] addr;
    logic [31:0] wbval;
    logic [31:0] rdata_r;
    logic [15:0] pend_clr;
    logic [31:0] span;
    logic        wb_go;

    function automatic logic [3:0] lowest(input logic [15:0] v);
        lowest = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (v[i-1]) lowest = 4'(i - 1);
        end
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] v);
        popcount = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            popcount = popcount + {4'd0, v[i]};
        end
    endfunction

    assign pend_clr = pend & ~(16'd1 << idx);
    assign span     = {25'd0, popcount(list_r), 2'b00};
    // A load that overwrites the base register takes precedence over writeback.
    assign wb_go    = wb_r && !(ld_r && list_r[rn_r]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and output decode
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        rf_A1     = '0;
        rf_A3     = '0;
        rf_WD3    = '0;
        rf_WE3    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (start) state_nx = BASE;
            end
            BASE: begin
                busy  = 1'b1;
                rf_A1 = rn_r;
                if (list_r == '0) state_nx = DONE;
                else              state_nx = XFER;
            end
            XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = !ld_r;
                mem_addr = addr;
                if (!ld_r) begin
                    rf_A1     = idx;
                    mem_wdata = rf_RD1;
                end
                if (mem_ack) begin
                    if (ld_r)              state_nx = LWR;
                    else if (pend_clr != '0) state_nx = XFER;
                    else if (wb_go)        state_nx = WB;
                    else                   state_nx = DONE;
                end
            end
            LWR: begin
                busy   = 1'b1;
                rf_WE3 = 1'b1;
                rf_A3  = idx;
                rf_WD3 = rdata_r;
                if (pend != '0) state_nx = XFER;
                else if (wb_go) state_nx = WB;
                else            state_nx = DONE;
            end
            WB: begin
                busy     = 1'b1;
                rf_WE3   = 1'b1;
                rf_A3    = rn_r;
                rf_WD3   = wbval;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: request latch, base/address tracking, list walk, load capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_r    <= 1'b0;
            wb_r    <= 1'b0;
            dec_r   <= 1'b0;
            rn_r    <= '0;
            list_r  <= '0;
            pend    <= '0;
            idx     <= '0;
            addr    <= '0;
            wbval   <= '0;
            rdata_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ld_r   <= is_load;
                        wb_r   <= wb_en;
                        rn_r   <= rn;
                        list_r <= reg_list;
`ifdef BLOCK_XFER_DB_EN
                        dec_r  <= decrement;
`else
                        dec_r  <= 1'b0;
`endif
                    end
                end
                BASE: begin
                    pend <= list_r;
                    idx  <= lowest(list_r);
                    // Decrement-before still walks upward from the lowest address.
                    if (dec_r) begin
                        addr  <= rf_RD1 - span;
                        wbval <= rf_RD1 - span;
                    end else begin
                        addr  <= rf_RD1;
                        wbval <= rf_RD1 + span;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        addr <= addr + 32'd4;
                        pend <= pend_clr;
                        if (ld_r) rdata_r <= mem_rdata;
                        else      idx     <= lowest(pend_clr);
                    end
                end
                LWR: begin
                    idx <= lowest(pend);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Scoreboard bench for block_xfer_seq: stimulus queues expected memory
// transactions, register-file writes and done pulses; a monitor pops them.
module tb_block_xfer_seq;

    logic        clk = 1'b0;
    logic        rst, start, is_load, wb_en;
    logic [3:0]  rn;
    logic [15:0] reg_list;
    logic        busy, done;
    logic [3:0]  rf_A1, rf_A3;
    logic [31:0] rf_RD1, rf_WD3;
    logic        rf_WE3, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        resp_ack, man_ack;

    logic [31:0] rf_regs [16];
    logic [31:0] mem_model [logic [31:0]];
    int          delay_q [$];

    typedef struct packed {
        logic [1:0]  kind;   // 0 mem, 1 rf write, 2 done
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t sb [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rf_RD1  = rf_regs[rf_A1];
    assign mem_ack = resp_ack | man_ack;

    block_xfer_seq dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .wb_en(wb_en),
        .rn(rn), .reg_list(reg_list), .busy(busy), .done(done),
        .rf_A1(rf_A1), .rf_RD1(rf_RD1), .rf_A3(rf_A3), .rf_WD3(rf_WD3),
        .rf_WE3(rf_WE3), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
        sb.push_back({2'd0, we, a, d});
    endtask
    task automatic exp_rf(input logic [3:0] a, input logic [31:0] d);
        sb.push_back({2'd1, 1'b0, {28'd0, a}, d});
    endtask
    task automatic exp_done();
        sb.push_back({2'd2, 1'b0, 32'd0, 32'd0});
    endtask

    function automatic void take(input string name, input ev_t act);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got kind=%0d we=%0d addr=%h data=%h, expected no event",
                     name, act.kind, act.we, act.addr, act.data);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got kind=%0d we=%0d addr=%h data=%h, expected kind=%0d we=%0d addr=%h data=%h",
                         name, act.kind, act.we, act.addr, act.data, e.kind, e.we, e.addr, e.data);
            end
        end
    endfunction

    // Memory responder: per-transaction wait states taken from delay_q
    initial begin
        int cnt;
        cnt = -1;
        resp_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                if (cnt < 0) cnt = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                if (cnt == 0) begin
                    resp_ack  = 1'b1;
                    mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hDEADBEEF;
                    cnt = -1;
                end else begin
                    resp_ack = 1'b0;
                    cnt--;
                end
            end else begin
                resp_ack = 1'b0;
                cnt = -1;
            end
        end
    end

    // Monitor: compare every observable DUT event against the scoreboard
    initial begin
        ev_t act;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (mem_req && mem_ack) begin
                    act = {2'd0, mem_we, mem_addr, mem_we ? mem_wdata : 32'd0};
                    take("mem", act);
                end else if (mem_req && sb.size() > 0 && sb[0].kind == 2'd0) begin
                    act = {2'd0, mem_we, mem_addr, mem_we ? mem_wdata : 32'd0};
                    check("mem_hold", {act.we, act.addr, act.data[30:0]},
                          {sb[0].we, sb[0].addr, sb[0].data[30:0]});
                end
                if (rf_WE3) begin
                    act = {2'd1, 1'b0, {28'd0, rf_A3}, rf_WD3};
                    take("rf", act);
                end
                if (done) begin
                    act = {2'd2, 1'b0, 32'd0, 32'd0};
                    take("done", act);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One operation; poke pulses a conflicting start while busy.
    task automatic run_op(input string name, input logic ld, input logic wb, input logic [3:0] r,
                          input logic [15:0] lst, input int exp_k, input int exp_busy, input bit poke);
        int k, nb;
        k = 0;
        nb = 0;
        start = 1'b1; is_load = ld; wb_en = wb; rn = r; reg_list = lst;
        @(posedge clk);
        while (k < 60) begin
            tick();
            k++;
            if (k == 1) start = 1'b0;
            if (poke && k == 3) begin
                start = 1'b1; is_load = 1'b1; rn = 4'd0; reg_list = 16'hFFFF;
            end
            if (poke && k == 4) start = 1'b0;
            if (done) break;
            if (busy) nb++;
        end
        check({name, "_done_cycle"}, 64'(k), 64'(exp_k));
        check({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf_regs[i] = 32'h1000_0000 + 32'(i);
        rf_regs[1] = 32'h100;
        rf_regs[2] = 32'h400;
        rf_regs[3] = 32'h500;
        rf_regs[4] = 32'h300;
        rf_regs[6] = 32'h200;
        mem_model[32'h200] = 32'hAAAA0000;
        mem_model[32'h204] = 32'hBBBB0005;
        mem_model[32'h300] = 32'h12345678;
        man_ack = 1'b0;
        rst = 1'b1; start = 1'b0; is_load = 1'b0; wb_en = 1'b0; rn = '0; reg_list = '0;
        repeat (3) tick();
        check("reset_outputs",
              64'({busy, done, rf_A1, rf_A3, rf_WD3, rf_WE3, mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
        rst = 1'b0;
        tick();

        // STM R2,R3 from base R1=0x100 with writeback
        exp_mem(1'b1, 32'h100, 32'h400);
        exp_mem(1'b1, 32'h104, 32'h500);
        exp_rf(4'd1, 32'h108);
        exp_done();
        run_op("stm_wb", 1'b0, 1'b1, 4'd1, 16'h000C, 5, 4, 1'b0);

        // LDM R0,R5 from base R6=0x200, no writeback
        exp_mem(1'b0, 32'h200, 32'h0);
        exp_rf(4'd0, 32'hAAAA0000);
        exp_mem(1'b0, 32'h204, 32'h0);
        exp_rf(4'd5, 32'hBBBB0005);
        exp_done();
        run_op("ldm", 1'b1, 1'b0, 4'd6, 16'h0021, 6, 5, 1'b0);

        // LDM with base in list: loaded value wins, no WB cycle
        exp_mem(1'b0, 32'h300, 32'h0);
        exp_rf(4'd4, 32'h12345678);
        exp_done();
        run_op("ldm_base_in_list", 1'b1, 1'b1, 4'd4, 16'h0010, 4, 3, 1'b0);

        // Empty list: no memory access, no writeback
        exp_done();
        run_op("empty", 1'b0, 1'b1, 4'd1, 16'h0000, 2, 1, 1'b0);

        // STM R0,R1,R8 with 3 wait states on the second transfer, start poked while busy
        delay_q.push_back(0);
        delay_q.push_back(3);
        delay_q.push_back(0);
        exp_mem(1'b1, 32'h400, 32'h1000_0000);
        exp_mem(1'b1, 32'h404, 32'h100);
        exp_mem(1'b1, 32'h408, 32'h1000_0008);
        exp_done();
        run_op("stm_wait", 1'b0, 1'b0, 4'd2, 16'h0103, 8, 7, 1'b1);

        // Reset while a store waits for mem_ack
        delay_q.push_back(8);
        start = 1'b1; is_load = 1'b0; wb_en = 1'b1; rn = 4'd3; reg_list = 16'h0006;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_req", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b1, 32'h500}));
        rst = 1'b1;
        tick();
        check("post_reset_outputs",
              64'({busy, done, rf_A1, rf_A3, rf_WD3, rf_WE3, mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
        rst = 1'b0;
        man_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_ack_quiet", 64'({rf_WE3, mem_req, busy}), 64'd0);
        end
        man_ack = 1'b0;
        delay_q.delete();
        tick();

        // Fresh operation after reset
        exp_mem(1'b1, 32'h100, 32'h400);
        exp_mem(1'b1, 32'h104, 32'h500);
        exp_rf(4'd1, 32'h108);
        exp_done();
        run_op("stm_after_reset", 1'b0, 1'b1, 4'd1, 16'h000C, 5, 4, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
